// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch master and
// the data-access master. Address-phase handshakes are serialised through a
// combinational grant; a grant that is stalled by the downstream port is
// locked until its address is accepted. The order in which addresses were
// accepted is kept in a small 1-bit FIFO so that each in-order data-phase
// response can be returned to the master that issued it.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  defined   -> alternate grants when both masters
//                                         request (last_src register)
//                            undefined -> fixed priority, data beats inst
//
// Parameters:
//   MAX_OUT  maximum outstanding transactions (power of two, 2..8)
//   ADDR_W   address width
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   inst_req/inst_addr              fetch request and address
//   inst_addr_ok/inst_data_ok       fetch address accepted / read data valid
//   inst_rdata                      fetch read data
//   data_req/data_wr/data_wstrb/
//   data_addr/data_wdata            data request and its qualifiers
//   data_addr_ok/data_data_ok       data address accepted / response valid
//   data_rdata                      data read data
//   mem_req/mem_wr/mem_wstrb/
//   mem_addr/mem_wdata              downstream request
//   mem_addr_ok/mem_data_ok/
//   mem_rdata                       downstream handshakes and read data
//   arb_err                         sticky: response seen with nothing pending
module sram_port_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,
  output logic              arb_err
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  // Source encoding used by grant, lock and the order FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic              lock_valid;
  logic              lock_src;
  logic [MAX_OUT-1:0] order_q;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  count;
  logic              arb_err_q;

  logic              grant;
  logic              full;
  logic              empty;
  logic              src_req;
  logic              push;
  logic              pop;
  logic              head_src;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic              last_src;
`endif

  assign full  = (count == CNT_W'(MAX_OUT));
  assign empty = (count == '0);

  // Grant selection. A locked grant always wins so that a request the bridge
  // has already seen is never withdrawn before its address is accepted.
  always_comb begin
    grant = SRC_INST;
    if (lock_valid) begin
      grant = lock_src;
    end else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (inst_req && data_req) begin
        grant = ~last_src;
      end else if (data_req) begin
        grant = SRC_DATA;
      end else begin
        grant = SRC_INST;
      end
`else
      grant = data_req ? SRC_DATA : SRC_INST;
`endif
    end
  end

  // Downstream request mux; fetches are always word reads.
  always_comb begin
    src_req   = inst_req;
    mem_wr    = 1'b0;
    mem_wstrb = 4'h0;
    mem_addr  = inst_addr;
    mem_wdata = 32'h0;
    if (grant == SRC_DATA) begin
      src_req   = data_req;
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // A full order FIFO blocks the request even if a pop happens this cycle,
  // keeping push and pop decisions independent of each other.
  assign mem_req = src_req && !full;
  assign push    = mem_req && mem_addr_ok;
  assign pop     = mem_data_ok && !empty;

  assign inst_addr_ok = push && (grant == SRC_INST);
  assign data_addr_ok = push && (grant == SRC_DATA);

  assign head_src     = order_q[head_ptr];
  assign inst_data_ok = pop && (head_src == SRC_INST);
  assign data_data_ok = pop && (head_src == SRC_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign arb_err    = arb_err_q;

  // Lock register: set by a stalled request, cleared by its acceptance,
  // untouched while the request is held off by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_src   <= SRC_INST;
    end else if (mem_req) begin
      if (mem_addr_ok) begin
        lock_valid <= 1'b0;
      end else begin
        lock_valid <= 1'b1;
        lock_src   <= grant;
      end
    end
  end

  // Order FIFO: one bit per accepted address, popped per response.
  always_ff @(posedge clk) begin
    if (reset) begin
      order_q  <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        order_q[tail_ptr] <= grant;
        tail_ptr          <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Sticky protocol error: a response arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_err_q <= 1'b0;
    end else if (mem_data_ok && empty) begin
      arb_err_q <= 1'b1;
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_src <= SRC_INST;
    end else if (push) begin
      last_src <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;
  logic              arb_err;

  int tests = 0;
  int fails = 0;

  sram_port_arbiter #(.MAX_OUT(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge, away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state with all inputs idle
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("rst_data_addr_ok", 32'(data_addr_ok), 0);
    check("rst_inst_data_ok", 32'(inst_data_ok), 0);
    check("rst_data_data_ok", 32'(data_data_ok), 0);
    check("rst_arb_err", 32'(arb_err), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 0);
    check("rst_count", 32'(dut.count), 0);

    // Zero-cycle fetch handshake
    inst_req = 1; inst_addr = 32'hbfc00000; mem_addr_ok = 1;
    settle();
    check("idle_mem_req", 32'(mem_req), 1);
    check("idle_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("idle_data_addr_ok", 32'(data_addr_ok), 0);
    check("idle_mem_addr", mem_addr, 32'hbfc00000);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    check("idle_count1", 32'(dut.count), 1);

    // Drain that fetch
    mem_data_ok = 1; mem_rdata = 32'haaaa5555;
    settle();
    check("drain_inst_data_ok", 32'(inst_data_ok), 1);
    check("drain_data_data_ok", 32'(data_data_ok), 0);
    check("drain_inst_rdata", inst_rdata, 32'haaaa5555);
    tick();
    mem_data_ok = 0;
    settle();
    check("drain_count0", 32'(dut.count), 0);

    // Stall then lock: fetch stalled, data arrives later but must wait
    inst_req = 1; inst_addr = 32'hbfc00000; mem_addr_ok = 0;
    settle();
    check("lock_c0_mem_req", 32'(mem_req), 1);
    check("lock_c0_inst_addr_ok", 32'(inst_addr_ok), 0);
    tick();
    data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h100; data_wdata = 32'hdeadbeef;
    settle();
    check("lock_c1_mem_addr", mem_addr, 32'hbfc00000);
    check("lock_c1_mem_wr", 32'(mem_wr), 0);
    check("lock_c1_data_addr_ok", 32'(data_addr_ok), 0);
    tick();
    check("lock_c2_mem_addr", mem_addr, 32'hbfc00000);
    check("lock_c2_mem_wstrb", 32'(mem_wstrb), 0);
    mem_addr_ok = 1;
    settle();
    check("lock_c2_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("lock_c2_data_addr_ok", 32'(data_addr_ok), 0);
    tick();
    inst_req = 0;
    settle();
    check("lock_c3_mem_addr", mem_addr, 32'h100);
    check("lock_c3_mem_wr", 32'(mem_wr), 1);
    check("lock_c3_mem_wstrb", 32'(mem_wstrb), 32'hf);
    check("lock_c3_mem_wdata", mem_wdata, 32'hdeadbeef);
    check("lock_c3_data_addr_ok", 32'(data_addr_ok), 1);
    tick();
    data_req = 0; data_wr = 0; data_wstrb = 0; mem_addr_ok = 0;
    settle();
    check("lock_count2", 32'(dut.count), 2);

    // Interleaved responses: inst first, then data
    mem_data_ok = 1; mem_rdata = 32'h1234;
    settle();
    check("resp1_inst_data_ok", 32'(inst_data_ok), 1);
    check("resp1_data_data_ok", 32'(data_data_ok), 0);
    check("resp1_inst_rdata", inst_rdata, 32'h1234);
    tick();
    mem_rdata = 32'h5678;
    settle();
    check("resp2_inst_data_ok", 32'(inst_data_ok), 0);
    check("resp2_data_data_ok", 32'(data_data_ok), 1);
    check("resp2_data_rdata", data_rdata, 32'h5678);
    tick();
    mem_data_ok = 0;
    settle();
    check("resp_count0", 32'(dut.count), 0);

    // Full: two accepted fetches, third held off until a pop has retired
    inst_req = 1; inst_addr = 32'h10; mem_addr_ok = 1;
    settle();
    check("full_h1", 32'(inst_addr_ok), 1);
    tick();
    inst_addr = 32'h14;
    settle();
    check("full_h2", 32'(inst_addr_ok), 1);
    tick();
    inst_addr = 32'h18;
    settle();
    check("full_count", 32'(dut.count), 2);
    check("full_mem_req", 32'(mem_req), 0);
    check("full_inst_addr_ok", 32'(inst_addr_ok), 0);
    mem_data_ok = 1; mem_rdata = 32'h11;
    settle();
    check("full_pop_inst_data_ok", 32'(inst_data_ok), 1);
    check("full_pop_mem_req", 32'(mem_req), 0);
    check("full_pop_inst_addr_ok", 32'(inst_addr_ok), 0);
    tick();
    mem_data_ok = 0;
    settle();
    check("full_next_mem_req", 32'(mem_req), 1);
    check("full_next_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("full_next_mem_addr", mem_addr, 32'h18);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    settle();
    check("full_count_after", 32'(dut.count), 2);
    mem_data_ok = 1;
    tick(); tick();
    mem_data_ok = 0;
    settle();
    check("full_drained", 32'(dut.count), 0);

    // Spurious response with nothing outstanding
    mem_data_ok = 1; mem_rdata = 32'h99;
    settle();
    check("spur_inst_data_ok", 32'(inst_data_ok), 0);
    check("spur_data_data_ok", 32'(data_data_ok), 0);
    tick();
    mem_data_ok = 0;
    settle();
    check("spur_arb_err", 32'(arb_err), 1);
    check("spur_count", 32'(dut.count), 0);
    tick(); tick();
    check("spur_arb_err_held", 32'(arb_err), 1);
    reset = 1;
    tick();
    reset = 0;
    settle();
    check("spur_arb_err_reset", 32'(arb_err), 0);

    // Both masters requesting continuously with the port always ready;
    // a response each cycle from the second on keeps the FIFO below full.
    inst_req = 1; inst_addr = 32'h40;
    data_req = 1; data_wr = 0; data_addr = 32'h80;
    mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_data;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_data = (i % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      settle();
      check($sformatf("both_%0d_data_addr_ok", i), 32'(data_addr_ok), 32'(exp_data));
      check($sformatf("both_%0d_inst_addr_ok", i), 32'(inst_addr_ok), 32'(!exp_data));
      check($sformatf("both_%0d_mem_addr", i), mem_addr, exp_data ? 32'h80 : 32'h40);
      tick();
      mem_data_ok = 1;
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    settle();
    check("both_count", 32'(dut.count), 1);
    tick();
    mem_data_ok = 0;
    settle();
    check("both_drained", 32'(dut.count), 0);
    check("both_arb_err", 32'(arb_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
